// File: rtl/sw_debounce.sv
// sw_debounce: switch / push-button debouncer.
// Raw inputs are synchronized into clk, then sampled on rising edges of a slow
// sampling clock (a clock-divider tap treated as data). A channel's clean level
// moves only after STABLE consecutive samples disagree with the current level.
// Optional feature macro: SW_DEBOUNCE_EDGE_EN enables the registered
// press/release pulses; without it both pulse outputs are constant 0.
module sw_debounce #(
    parameter int N      = 8,
    parameter int STABLE = 4,
    parameter int CNT_W  = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         samp_clk,
    input  logic [N-1:0] raw_in,
    output logic [N-1:0] level,
    output logic [N-1:0] pressed,
    output logic [N-1:0] released
);

    // The count that completes a run of STABLE differing samples.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE - 1);

    logic [N-1:0]     in_meta_reg;
    logic [N-1:0]     sync_in_reg;
    logic             samp_meta_reg;
    logic             sync_samp_reg;
    logic             sync_samp_d_reg;
    logic             strobe;

    logic [CNT_W-1:0] cnt_reg  [N];
    logic [CNT_W-1:0] cnt_next [N];
    logic [N-1:0]     level_reg;
    logic [N-1:0]     level_next;
    logic [N-1:0]     accept;

    // Two-flop synchronizers for the raw levels and the sampling clock, plus
    // one extra flop on the sampling clock for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_meta_reg     <= '0;
            sync_in_reg     <= '0;
            samp_meta_reg   <= 1'b0;
            sync_samp_reg   <= 1'b0;
            sync_samp_d_reg <= 1'b0;
        end else begin
            in_meta_reg     <= raw_in;
            sync_in_reg     <= in_meta_reg;
            samp_meta_reg   <= samp_clk;
            sync_samp_reg   <= samp_meta_reg;
            sync_samp_d_reg <= sync_samp_reg;
        end
    end

    // One clk cycle per sampling-clock rising edge.
    assign strobe = sync_samp_reg & ~sync_samp_d_reg;

    // Per-channel counter and acceptance decision. A sample equal to the
    // current level restarts the run; the counter is cleared on acceptance,
    // so it never climbs past CNT_LAST.
    for (genvar gi = 0; gi < N; gi++) begin : g_chan
        logic differ;
        logic at_last;

        assign differ      = sync_in_reg[gi] ^ level_reg[gi];
        assign at_last     = (cnt_reg[gi] == CNT_LAST);
        assign accept[gi]  = strobe & differ & at_last;
        assign cnt_next[gi] = !strobe             ? cnt_reg[gi] :
                              (!differ || at_last) ? '0 :
                              cnt_reg[gi] + CNT_W'(1);
    end

    // An accepted channel always flips, since it only accepts on a difference.
    assign level_next = level_reg ^ accept;

    // Counter and debounced-level state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_reg <= '0;
            for (int i = 0; i < N; i++) begin
                cnt_reg[i] <= '0;
            end
        end else begin
            level_reg <= level_next;
            for (int i = 0; i < N; i++) begin
                cnt_reg[i] <= cnt_next[i];
            end
        end
    end

    assign level = level_reg;

`ifdef SW_DEBOUNCE_EDGE_EN
    logic [N-1:0] pressed_reg;
    logic [N-1:0] released_reg;

    // Pulses are registered on the same edge as the level change so they
    // appear in the first cycle of the new level and clear one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pressed_reg  <= '0;
            released_reg <= '0;
        end else begin
            pressed_reg  <= accept & sync_in_reg;
            released_reg <= accept & ~sync_in_reg;
        end
    end

    assign pressed  = pressed_reg;
    assign released = released_reg;
`else
    assign pressed  = '0;
    assign released = '0;
`endif

endmodule
